// File: rtl/mips_mem_pkg.sv
// Address map, IO register offsets and responder FSM states for the MIPS data memory.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
    localparam logic [31:0] IO_BASE   = 32'h1002_0000;

    localparam logic [31:0] LED_OFF   = 32'h0000_0000;
    localparam logic [31:0] CYC_OFF   = 32'h0000_0004;
    localparam logic [31:0] STAT_OFF  = 32'h0000_0008;

    localparam logic [31:0] LED_ADDR  = IO_BASE + LED_OFF;
    localparam logic [31:0] CYC_ADDR  = IO_BASE + CYC_OFF;
    localparam logic [31:0] STAT_ADDR = IO_BASE + STAT_OFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Nloc x Dbits word RAM: one asynchronous read port, one synchronous write port.
// Latency: read combinational, write commits on the rising edge.
// Backpressure: none; the caller gates the write enable.
module dmem_ram #(
    parameter int Nloc  = 64,
    parameter int Dbits = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Nloc)-1:0]  waddr,
    input  logic [Dbits-1:0]         wdata,
    input  logic [$clog2(Nloc)-1:0]  raddr,
    output logic [Dbits-1:0]         rdata
);

    logic [Dbits-1:0] mem_q [Nloc];

    // Storage is deliberately not reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM plus LED / free-running CYCLES / sticky-error STATUS registers.
// Latency: writes zero-wait; reads combinational (WAIT=0) or WAIT stall cycles via IDLE/BUSY/DONE.
// Backpressure: enable low stalls the core while a read is in flight; writes are gated by enable.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int Nloc  = 64,
    parameter int Dbits = 32,
    parameter int WAIT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [31:0]      mem_addr,
    input  logic [Dbits-1:0] mem_writedata,
    output logic [Dbits-1:0] mem_readdata,
    output logic             enable,
    output logic [15:0]      led
);

    localparam int AW = $clog2(Nloc);

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:2]      addr_q, addr_d;
    logic [Dbits-1:0] rdata_q, rdata_d;
    logic [15:0]      led_q, led_d;
    logic [31:0]      cycles_q, cycles_d;
    logic             err_q, err_d;

    logic [31:2]      rd_addr;
    logic [Dbits-1:0] rd_val;
    logic             rd_mapped;
    logic             rd_fire;
    logic             wr_fire;
    logic             collide;
    logic             ram_we;
    logic [Dbits-1:0] ram_rdata;

    // Byte-lane bits carry no meaning for word accesses.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^mem_addr[1:0];

    function automatic logic in_ram(input logic [31:2] a);
        return a[31:AW+2] == RAM_BASE[31:AW+2];
    endfunction

    dmem_ram #(
        .Nloc  (Nloc),
        .Dbits (Dbits)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (mem_addr[AW+1:2]),
        .wdata (mem_writedata),
        .raddr (rd_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

    // Read address: live bus when combinational or just being accepted, else the latched one.
    always_comb begin
        rd_addr = (WAIT == 0 || state_q == ST_IDLE) ? mem_addr[31:2] : addr_q;
    end

    // Read mux over RAM and IO registers; anything else reads as zero and is flagged.
    always_comb begin
        rd_val    = '0;
        rd_mapped = 1'b1;
        if (in_ram(rd_addr)) begin
            rd_val = ram_rdata;
        end else if (rd_addr == LED_ADDR[31:2]) begin
            rd_val = Dbits'(led_q);
        end else if (rd_addr == CYC_ADDR[31:2]) begin
            rd_val = Dbits'(cycles_q);
        end else if (rd_addr == STAT_ADDR[31:2]) begin
            rd_val = Dbits'(err_q);
        end else begin
            rd_mapped = 1'b0;
        end
    end

    // Wait-state FSM: enable, next state, countdown, address latch and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        enable  = 1'b1;
        rd_fire = 1'b0;
        if (WAIT == 0) begin
            rd_fire = mem_rd & ~mem_wr;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A simultaneous store must still go through, so only a pure load stalls.
                    enable = ~(mem_rd & ~mem_wr);
                    if (mem_rd && !mem_wr) begin
                        addr_d  = mem_addr[31:2];
                        cnt_d   = 2'(WAIT - 1);
                        state_d = (WAIT == 1) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    enable = 1'b0;
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                rd_fire = 1'b1;
                rdata_d = rd_val;
            end
        end
    end

    // Store decode, free-running cycle counter and sticky error flag.
    always_comb begin
        wr_fire  = mem_wr & enable;
        collide  = mem_rd & mem_wr & (WAIT == 0 || state_q == ST_IDLE);
        ram_we   = wr_fire & in_ram(mem_addr[31:2]);
        led_d    = led_q;
        err_d    = err_q;
        cycles_d = cycles_q + 32'd1;
        if (wr_fire && !in_ram(mem_addr[31:2])) begin
            if (mem_addr[31:2] == LED_ADDR[31:2]) begin
                led_d = mem_writedata[15:0];
            end else if (mem_addr[31:2] == STAT_ADDR[31:2]) begin
                err_d = 1'b0;
            end else if (mem_addr[31:2] != CYC_ADDR[31:2]) begin
                err_d = 1'b1;
            end
        end
        if ((rd_fire && !rd_mapped) || collide) begin
            err_d = 1'b1;
        end
    end

    // State registers; RAM contents live in dmem_ram and are untouched by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            led_q    <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            led_q    <= led_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
        end
    end

    assign mem_readdata = (WAIT == 0) ? rd_val : rdata_q;
    assign led          = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at WAIT=0, 2 and 3 with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: stall cycles are counted explicitly against the configured wait states.
module tb_dmem_responder;

    logic             clk = 1'b0;
    logic [2:0]       rst;
    logic [2:0]       rd;
    logic [2:0]       wr;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdat;
    logic [2:0][31:0] rdat;
    logic [2:0]       en;
    logic [2:0][15:0] led;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_responder #(.Nloc(64), .Dbits(32), .WAIT(0)) u_w0 (
        .clk(clk), .reset(rst[0]), .mem_rd(rd[0]), .mem_wr(wr[0]), .mem_addr(addr[0]),
        .mem_writedata(wdat[0]), .mem_readdata(rdat[0]), .enable(en[0]), .led(led[0]));

    dmem_responder #(.Nloc(64), .Dbits(32), .WAIT(2)) u_w2 (
        .clk(clk), .reset(rst[1]), .mem_rd(rd[1]), .mem_wr(wr[1]), .mem_addr(addr[1]),
        .mem_writedata(wdat[1]), .mem_readdata(rdat[1]), .enable(en[1]), .led(led[1]));

    dmem_responder #(.Nloc(64), .Dbits(32), .WAIT(3)) u_w3 (
        .clk(clk), .reset(rst[2]), .mem_rd(rd[2]), .mem_wr(wr[2]), .mem_addr(addr[2]),
        .mem_writedata(wdat[2]), .mem_readdata(rdat[2]), .enable(en[2]), .led(led[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Store: one cycle, enable must be high, commit on the next edge.
    task automatic sw(input int i, input logic [31:0] a, input logic [31:0] d);
        wr[i]   = 1'b1;
        addr[i] = a;
        wdat[i] = d;
        @(negedge clk);
        check("sw_enable", 32'(en[i]), 32'd1);
        next_cycle();
        wr[i] = 1'b0;
    endtask

    // Load with w stall cycles; for w>0 also checks the idle cycle after and that data holds.
    task automatic lw(input int i, input int w, input logic [31:0] a,
                      input logic [31:0] exp, input string tag);
        rd[i]   = 1'b1;
        addr[i] = a;
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            check({tag, "_stall"}, 32'(en[i]), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check({tag, "_en"}, 32'(en[i]), 32'd1);
        check(tag, rdat[i], exp);
        next_cycle();
        rd[i] = 1'b0;
        if (w > 0) begin
            @(negedge clk);
            check({tag, "_idle_en"}, 32'(en[i]), 32'd1);
            check({tag, "_hold"}, rdat[i], exp);
            next_cycle();
        end
    endtask

    initial begin
        rst  = 3'b111;
        rd   = '0;
        wr   = '0;
        addr = '0;
        wdat = '0;
        @(negedge clk);
        check("rst_led_w0", 32'(led[0]), 32'd0);
        check("rst_en_w0", 32'(en[0]), 32'd1);
        check("rst_rdat_w2", rdat[1], 32'd0);
        check("rst_en_w2", 32'(en[1]), 32'd1);
        #2;
        rst = 3'b000;
        next_cycle();

        // ---------------- WAIT=0 ----------------
        sw(0, 32'h1001_0004, 32'hDEAD_BEEF);
        lw(0, 0, 32'h1001_0004, 32'hDEAD_BEEF, "w0_ram_rd");
        lw(0, 0, 32'h1001_0007, 32'hDEAD_BEEF, "w0_lsb_ignored");
        sw(0, 32'h1002_0000, 32'h0000_A5A5);
        check("w0_led", 32'(led[0]), 32'h0000_A5A5);
        lw(0, 0, 32'h1002_0000, 32'h0000_A5A5, "w0_led_rd");
        lw(0, 0, 32'h1002_0008, 32'd0, "w0_status_clean");
        lw(0, 0, 32'h2000_0000, 32'd0, "w0_unmapped_rd");
        lw(0, 0, 32'h1002_0008, 32'd1, "w0_status_set");
        sw(0, 32'h1002_0008, 32'h1234_5678);
        lw(0, 0, 32'h1002_0008, 32'd0, "w0_status_clr");
        sw(0, 32'h1002_0004, 32'h0000_0055);
        lw(0, 0, 32'h1002_0008, 32'd0, "w0_cyc_wr_noerr");
        sw(0, 32'h1001_00FC, 32'h1357_9BDF);
        lw(0, 0, 32'h1001_00FC, 32'h1357_9BDF, "w0_ram_last");
        lw(0, 0, 32'h1001_0100, 32'd0, "w0_ram_past_end");
        lw(0, 0, 32'h1002_0008, 32'd1, "w0_past_end_err");
        sw(0, 32'h1002_0008, 32'd0);
        sw(0, 32'h3000_0000, 32'h0000_0001);
        lw(0, 0, 32'h1002_0008, 32'd1, "w0_unmapped_wr_err");
        sw(0, 32'h1002_0008, 32'd0);

        // Counter wrap: preload all-ones, the next edge must roll it to zero.
        @(negedge clk);
        force u_w0.cycles_q = 32'hFFFF_FFFF;
        #1;
        release u_w0.cycles_q;
        lw(0, 0, 32'h1002_0004, 32'd0, "w0_cyc_wrap");
        lw(0, 0, 32'h1002_0004, 32'd1, "w0_cyc_after_wrap");

        // Load and store together: store lands, load dropped, error flagged.
        rd[0] = 1'b1; wr[0] = 1'b1;
        addr[0] = 32'h1001_0008; wdat[0] = 32'h1234_5678;
        @(negedge clk);
        check("w0_collide_en", 32'(en[0]), 32'd1);
        next_cycle();
        rd[0] = 1'b0; wr[0] = 1'b0;
        lw(0, 0, 32'h1001_0008, 32'h1234_5678, "w0_collide_wr");
        lw(0, 0, 32'h1002_0008, 32'd1, "w0_collide_err");

        // ---------------- WAIT=2 ----------------
        sw(1, 32'h1001_0004, 32'hDEAD_BEEF);
        lw(1, 2, 32'h1001_0004, 32'hDEAD_BEEF, "w2_ram_rd");
        lw(1, 2, 32'h2000_0000, 32'd0, "w2_unmapped_rd");
        lw(1, 2, 32'h1002_0008, 32'd1, "w2_status_set");
        sw(1, 32'h1002_0008, 32'd0);
        lw(1, 2, 32'h1002_0008, 32'd0, "w2_status_clr");

        // ---------------- WAIT=3 ----------------
        sw(2, 32'h1001_000C, 32'hCAFE_F00D);
        sw(2, 32'h1002_0000, 32'h0000_1234);
        check("w3_led", 32'(led[2]), 32'h0000_1234);
        rd[2] = 1'b1; addr[2] = 32'h1001_000C;
        @(negedge clk);
        check("w3_pre_rst_stall0", 32'(en[2]), 32'd0);
        next_cycle();
        @(negedge clk);
        check("w3_pre_rst_stall1", 32'(en[2]), 32'd0);
        rst[2] = 1'b1;
        #1;
        check("w3_rst_en_rd", 32'(en[2]), 32'd0);
        check("w3_rst_led", 32'(led[2]), 32'd0);
        check("w3_rst_rdat", rdat[2], 32'd0);
        rd[2] = 1'b0;
        #1;
        check("w3_rst_en_idle", 32'(en[2]), 32'd1);
        next_cycle();
        rst[2] = 1'b0;
        // Counter starts at 0 here; sampled at the third edge after the request it reads 2.
        lw(2, 3, 32'h1002_0004, 32'd2, "w3_cyc_after_rst");
        lw(2, 3, 32'h1001_000C, 32'hCAFE_F00D, "w3_ram_kept");
        check("w3_led_after", 32'(led[2]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
